// File: rtl/sort_result_streamer.sv
// Reads the sorter result RAM from address 0 to DEPTH-1 and streams each word with its index and a last marker.
// The order of the stream is checked as it goes out; order_err is sticky until the next start.
//   state  | meaning
//   IDLE   | wait for a rising edge on sort_done
//   RD     | one-cycle read strobe at idx
//   WAIT   | count down the RAM read latency, then capture the word
//   OUT    | hold the word on the stream until it is accepted
//   FIN    | stream finished, wait for sort_done to drop
module sort_result_streamer #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  parameter  int RD_LAT = 1,
  parameter  int ORDER  = 0,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sort_done,
  output logic              ram_rd_en,
  output logic [IDX_W-1:0]  ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              stream_done,
  output logic              order_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               done_q;
  logic               start;
  logic [1:0]         lat_cnt;
  logic               capture;
  logic               violation;
  logic               have_prev;
  logic [DATA_W-1:0]  prev;
  logic [IDX_W-1:0]   idx;

  assign start   = sort_done & ~done_q;
  assign capture = (state == S_WAIT) && (lat_cnt == 2'd1);

  // Equal neighbours are legal in either direction.
  always_comb begin
    violation = 1'b0;
    if (ORDER == 0) violation = (ram_rdata < prev);
    else            violation = (ram_rdata > prev);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RD;
      S_RD:   state_nxt = S_WAIT;
      S_WAIT: if (capture) state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = out_last ? S_FIN : S_RD;
      S_FIN:  if (!sort_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_rd_en = (state == S_RD);
    ram_addr  = (state == S_RD) ? idx : '0;
    out_valid = (state == S_OUT);
    busy      = (state == S_RD) || (state == S_WAIT) || (state == S_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      idx         <= '0;
      lat_cnt     <= '0;
      out_data    <= '0;
      out_index   <= '0;
      out_last    <= 1'b0;
      prev        <= '0;
      have_prev   <= 1'b0;
      order_err   <= 1'b0;
      stream_done <= 1'b0;
    end else begin
      done_q      <= sort_done;
      stream_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            order_err <= 1'b0;
            have_prev <= 1'b0;
          end
        end
        S_RD: lat_cnt <= 2'(RD_LAT);
        S_WAIT: begin
          if (capture) begin
            out_data  <= ram_rdata;
            out_index <= idx;
            out_last  <= (idx == IDX_W'(DEPTH - 1));
            if (have_prev && violation) order_err <= 1'b1;
            prev      <= ram_rdata;
            have_prev <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_last) stream_done <= 1'b1;
            else          idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed bench: instance a uses RD_LAT=1/ascending, instance b uses RD_LAT=3/descending.
// Each observation is taken 1 time unit after a rising edge; index e means "sampled by edge E0+e".
module tb_sort_result_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sort_done_a = 1'b0, ready_a = 1'b1;
  logic       rd_en_a, valid_a, last_a, busy_a, sdone_a, err_a;
  logic [2:0] addr_a, index_a;
  logic [7:0] rdata_a, data_a;
  logic [7:0] mem_a [8];

  logic       sort_done_b = 1'b0, ready_b = 1'b1;
  logic       rd_en_b, valid_b, last_b, busy_b, sdone_b, err_b;
  logic [2:0] addr_b, index_b;
  logic [7:0] rdata_b, data_b, p1_b, p2_b;
  logic [7:0] mem_b [8];

  sort_result_streamer #(.DATA_W(8), .DEPTH(8), .RD_LAT(1), .ORDER(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sort_done(sort_done_a), .ram_rd_en(rd_en_a), .ram_addr(addr_a),
    .ram_rdata(rdata_a), .out_data(data_a), .out_index(index_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_last(last_a), .busy(busy_a), .stream_done(sdone_a), .order_err(err_a));

  sort_result_streamer #(.DATA_W(8), .DEPTH(8), .RD_LAT(3), .ORDER(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sort_done(sort_done_b), .ram_rd_en(rd_en_b), .ram_addr(addr_b),
    .ram_rdata(rdata_b), .out_data(data_b), .out_index(index_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_last(last_b), .busy(busy_b), .stream_done(sdone_b), .order_err(err_b));

  always @(posedge clk) rdata_a <= mem_a[addr_a];
  always @(posedge clk) begin
    p1_b    <= mem_b[addr_b];
    p2_b    <= p1_b;
    rdata_b <= p2_b;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] asc [8] = '{8'h03, 8'h07, 8'h0A, 8'h11, 8'h22, 8'h40, 8'h80, 8'hFF};
  logic [7:0] dsc [8] = '{8'hFF, 8'hE0, 8'hC0, 8'hA0, 8'h80, 8'h40, 8'h20, 8'h00};

  logic [7:0] g_data [16];
  logic [2:0] g_idx  [16];
  logic       g_last [16];
  logic       g_err  [16];
  int         g_edge [16];
  int         n_got, n_done, done_edge, stab_bad;
  logic       err_e1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records every handshake of instance a after sort_done_a was raised at the current time.
  task automatic collect_a(input int max_e, input bit rnd);
    logic [7:0] hd;
    logic [2:0] hi;
    logic       hl;
    bit         hold;
    n_got = 0; n_done = 0; done_edge = -1; stab_bad = 0; hold = 0; err_e1 = 1'bx;
    hd = '0; hi = '0; hl = 1'b0;
    for (int e = 0; e < max_e; e++) begin
      ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (e == 1) err_e1 = err_a;
      if (sdone_a) begin
        n_done++;
        if (done_edge < 0) done_edge = e;
      end
      if (hold && (!valid_a || data_a !== hd || index_a !== hi || last_a !== hl)) stab_bad++;
      if (valid_a && ready_a) begin
        if (n_got < 16) begin
          g_data[n_got] = data_a; g_idx[n_got] = index_a; g_last[n_got] = last_a;
          g_err[n_got] = err_a; g_edge[n_got] = e;
        end
        n_got++;
        hold = 0;
      end else if (valid_a) begin
        hold = 1; hd = data_a; hi = index_a; hl = last_a;
      end else begin
        hold = 0;
      end
      if (done_edge >= 0 && e >= done_edge + 3) break;
      step();
    end
    ready_a = 1'b1;
  endtask

  task automatic collect_b(input int max_e);
    n_got = 0; n_done = 0; done_edge = -1;
    for (int e = 0; e < max_e; e++) begin
      if (sdone_b) begin
        n_done++;
        if (done_edge < 0) done_edge = e;
      end
      if (valid_b && ready_b) begin
        if (n_got < 16) begin
          g_data[n_got] = data_b; g_idx[n_got] = index_b; g_last[n_got] = last_b;
          g_err[n_got] = err_b; g_edge[n_got] = e;
        end
        n_got++;
      end
      if (done_edge >= 0 && e >= done_edge + 3) break;
      step();
    end
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    #2;
    obs = {rd_en_a, addr_a, data_a, index_a, valid_a, last_a, busy_a, sdone_a, err_a};
    n_cmp++;
    if (obs !== 23'd0) begin n_bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({busy_a, busy_b, valid_a, valid_b} !== 4'd0) begin
      n_bad++; $display("FAIL reset_idle got=%b want=0000", {busy_a, busy_b, valid_a, valid_b});
    end
  endtask

  task automatic test_ascending();
    for (int i = 0; i < 8; i++) mem_a[i] = asc[i];
    sort_done_a = 1'b1;
    collect_a(60, 0);
    n_cmp++;
    if (n_got != 8) begin n_bad++; $display("FAIL asc_count got=%0d want=8", n_got); end
    for (int i = 0; i < 8 && i < n_got; i++) begin
      n_cmp++;
      if (g_data[i] !== asc[i] || g_idx[i] !== 3'(i) || g_last[i] !== (i == 7) || g_edge[i] != 3 + 3 * i) begin
        n_bad++;
        $display("FAIL asc_word%0d got=%h/%0d/%b@%0d want=%h/%0d/%b@%0d", i, g_data[i], g_idx[i], g_last[i],
                 g_edge[i], asc[i], i, (i == 7), 3 + 3 * i);
      end
    end
    n_cmp++;
    if (n_done != 1 || done_edge != 25) begin
      n_bad++; $display("FAIL asc_stream_done got=%0d@%0d want=1@25", n_done, done_edge);
    end
    n_cmp++;
    if (err_a !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL asc_final got=err%b busy%b want=err0 busy0", err_a, busy_a);
    end
  endtask

  task automatic test_hold_high();
    int act = 0;
    for (int c = 0; c < 100; c++) begin
      if (valid_a || busy_a || rd_en_a || sdone_a) act++;
      step();
    end
    n_cmp++;
    if (act != 0) begin n_bad++; $display("FAIL hold_high_retrigger got=%0d active cycles want=0", act); end
  endtask

  task automatic test_ready_random();
    sort_done_a = 1'b0;
    step(); step();
    sort_done_a = 1'b1;
    collect_a(400, 1);
    n_cmp++;
    if (n_got != 8 || n_done != 1) begin
      n_bad++; $display("FAIL rnd_count got=%0d words %0d done want=8 words 1 done", n_got, n_done);
    end
    for (int i = 0; i < 8 && i < n_got; i++) begin
      n_cmp++;
      if (g_data[i] !== asc[i] || g_idx[i] !== 3'(i)) begin
        n_bad++; $display("FAIL rnd_word%0d got=%h/%0d want=%h/%0d", i, g_data[i], g_idx[i], asc[i], i);
      end
    end
    n_cmp++;
    if (stab_bad != 0) begin n_bad++; $display("FAIL rnd_stability got=%0d changes want=0", stab_bad); end
  endtask

  task automatic test_order_err();
    logic [7:0] bad [8] = '{8'h05, 8'h05, 8'h09, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40};
    sort_done_a = 1'b0;
    step(); step();
    for (int i = 0; i < 8; i++) mem_a[i] = bad[i];
    sort_done_a = 1'b1;
    collect_a(60, 0);
    n_cmp++;
    if (n_got != 8) begin n_bad++; $display("FAIL err_count got=%0d want=8", n_got); end
    n_cmp++;
    if ({g_err[0], g_err[1], g_err[2], g_err[3], g_err[7]} !== 5'b00011) begin
      n_bad++;
      $display("FAIL err_flag got=%b want=00011", {g_err[0], g_err[1], g_err[2], g_err[3], g_err[7]});
    end
    sort_done_a = 1'b0;
    step(); step();
    n_cmp++;
    if (err_a !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b want=1", err_a); end
    for (int i = 0; i < 8; i++) mem_a[i] = asc[i];
    sort_done_a = 1'b1;
    collect_a(60, 0);
    n_cmp++;
    if (err_e1 !== 1'b0 || err_a !== 1'b0 || n_got != 8) begin
      n_bad++; $display("FAIL err_clear got=%b/%b/%0d want=0/0/8", err_e1, err_a, n_got);
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] obs;
    bit found = 0;
    sort_done_a = 1'b0;
    step(); step();
    sort_done_a = 1'b1;
    ready_a = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (valid_a && index_a == 3'd4) begin found = 1; break; end
      step();
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL rst_reach_idx4 got=0 want=1"); end
    rst_n = 1'b0;
    #1;
    obs = {rd_en_a, addr_a, data_a, index_a, valid_a, last_a, busy_a, sdone_a, err_a};
    n_cmp++;
    if (obs !== 23'd0) begin n_bad++; $display("FAIL rst_mid_outputs got=%h want=0", obs); end
    step();
    rst_n = 1'b1;
    collect_a(60, 0);
    n_cmp++;
    if (n_got != 8 || g_idx[0] !== 3'd0 || g_data[0] !== asc[0] || g_edge[0] != 3 || n_done != 1) begin
      n_bad++;
      $display("FAIL rst_restart got=%0d words idx%0d %h @%0d done%0d want=8 words idx0 03 @3 done1",
               n_got, g_idx[0], g_data[0], g_edge[0], n_done);
    end
  endtask

  task automatic test_lat3_desc();
    logic [7:0] bad [8] = '{8'h80, 8'h70, 8'h70, 8'h90, 8'h20, 8'h10, 8'h08, 8'h00};
    for (int i = 0; i < 8; i++) mem_b[i] = dsc[i];
    sort_done_b = 1'b1;
    collect_b(80);
    n_cmp++;
    if (n_got != 8 || n_done != 1) begin
      n_bad++; $display("FAIL lat3_count got=%0d words %0d done want=8 words 1 done", n_got, n_done);
    end
    for (int i = 0; i < 8 && i < n_got; i++) begin
      n_cmp++;
      if (g_data[i] !== dsc[i] || g_idx[i] !== 3'(i) || g_last[i] !== (i == 7) || g_edge[i] != 5 + 5 * i
          || g_err[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL lat3_word%0d got=%h/%0d/%b/err%b@%0d want=%h/%0d/%b/err0@%0d", i, g_data[i], g_idx[i],
                 g_last[i], g_err[i], g_edge[i], dsc[i], i, (i == 7), 5 + 5 * i);
      end
    end
    sort_done_b = 1'b0;
    step(); step();
    for (int i = 0; i < 8; i++) mem_b[i] = bad[i];
    sort_done_b = 1'b1;
    collect_b(80);
    n_cmp++;
    if (n_got != 8 || {g_err[1], g_err[2], g_err[3], g_err[6]} !== 4'b0011) begin
      n_bad++;
      $display("FAIL lat3_err got=%0d words flags %b want=8 words flags 0011", n_got,
               {g_err[1], g_err[2], g_err[3], g_err[6]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ascending();
    test_hold_high();
    test_ready_random();
    test_order_err();
    test_reset_mid();
    test_lat3_desc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sort_result_streamer.md
# sort_result_streamer

Downstream stage of the 8-entry ascending sorter. When the sorter raises `done`, this block walks the sorter's result RAM from address 0 to DEPTH-1 through its read port. It emits each word on a valid/ready stream with index and last markers, and it checks on the fly that the emitted sequence is correctly ordered. It replaces bench-side inspection of `ram1_data_out` with a synthesizable consumer that hardware downstream of the sorter can use.

## Interface
- `DATA_W`, 8, word width of the sorter RAM.
- `DEPTH`, 8, number of entries to stream (>= 2); `IDX_W` = $clog2(DEPTH).
- `RD_LAT`, 1, RAM read latency in cycles (1..3).
- `ORDER`, 0, expected order: 0 = non-decreasing (ascending RAM), 1 = non-increasing (descending RAM).

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sort_done`  in  1  sorter `done`, level, held high after sorting.
- `ram_rd_en`  out  1  read strobe to sorter RAM.
- `ram_addr`  out  IDX_W  read address.
- `ram_rdata`  in  DATA_W  read data, valid RD_LAT cycles after the cycle in which `ram_rd_en` is high.
- `out_data`  out  DATA_W  streamed word.
- `out_index`  out  IDX_W  RAM address of `out_data`.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts.
- `out_last`  out  1  high with the word at index DEPTH-1.
- `busy`  out  1  high in RD, WAIT, OUT.
- `stream_done`  out  1  one-cycle pulse after the last word is accepted.
- `order_err`  out  1  sticky; a word violated ORDER.

## Operation
- States: IDLE, RD, WAIT, OUT, FIN.
- The block registers `sort_done` into `done_q`. Start condition: `sort_done`=1 and `done_q`=0, i.e. a rising edge.
- IDLE: on start, go to RD with idx=0, clear `order_err`, clear the `have_prev` flag.
- RD: `ram_rd_en`=1 and `ram_addr`=idx for exactly one cycle, then go to WAIT with the latency counter = RD_LAT.
- WAIT: count down. On the cycle where `ram_rdata` is valid, capture it into `out_data`, set `out_index`=idx, `out_last`=(idx==DEPTH-1), then go to OUT.
- Order check at capture, when `have_prev`=1: ORDER=0 flags captured < prev; ORDER=1 flags captured > prev. On a violation set `order_err`. Equal values never flag. After the check, prev = captured and `have_prev`=1.
- OUT: `out_valid`=1. `out_data`, `out_index` and `out_last` stay stable until `out_valid & out_ready`. On the handshake:
  - if `out_last`: go to FIN and pulse `stream_done`;
  - otherwise: idx+1, go to RD.
- FIN: wait until `sort_done`=0, then go to IDLE. A `sort_done` held high never retriggers the block.
- `sort_done` falling during RD, WAIT or OUT is ignored; the current stream completes.
- `ram_addr` is 0 whenever `ram_rd_en`=0.

## Timing
- Reset (async assert, sync-released deassert) sets state IDLE, idx=0, and `done_q`=0.
- All outputs reset to 0: `ram_rd_en`, `ram_addr`, `out_data`, `out_index`, `out_valid`, `out_last`, `busy`, `stream_done`, `order_err`.
- Reset mid-stream drops `out_valid` immediately. After release, if `sort_done` is still high, `done_q`=0 makes it look like a rising edge, so streaming restarts from address 0.
- Edge E0 samples `sort_done`=1 with `done_q`=0. The cycle after E0 is RD. Data is captured at edge E0+1+RD_LAT. `out_valid` is high from the cycle after that edge: first valid 2+RD_LAT cycles after E0.
- With `out_ready` held at 1, consecutive words are 2+RD_LAT cycles apart. Full stream for DEPTH=8, RD_LAT=1: last handshake 24 cycles after E0.
- `stream_done` is high in the cycle after the last handshake, together with the first FIN cycle.
- `order_err` updates in the same cycle as `out_valid` for the offending word, and holds until the next start or reset.

## Test plan
- Ascending data 03,07,0A,11,22,40,80,FF; ready=1; RD_LAT=1 -> words in order, `out_index` 0..7, `out_last` only on FF, first valid 3 cycles after E0, `stream_done` once, `order_err`=0.
- Same data with `out_ready` toggled pseudo-randomly -> identical sequence; each word stable while unaccepted; no duplicates or drops.
- RAM 05,05,09,02,… with ORDER=0 -> `order_err` rises with word index 3 (02) and stays high through FIN. A new `sort_done` edge clears it.
- `sort_done` held high for 100 cycles after the stream -> exactly one stream. Dropping and re-raising it -> a second full stream.
- `rst_n` pulsed low during OUT of index 4 -> all outputs 0 at once. With `sort_done` still high, the stream restarts at index 0.
- RD_LAT=3, ORDER=1, descending data FF..00 -> first valid 5 cycles after E0, 5-cycle spacing, `order_err`=0.
